// File: rtl/wishbone_interconnect_2s.sv
// wishbone_interconnect_2s
// Single-master, two-slave Wishbone interconnect. Slave 0 is the device ROM
// table and slave 1 is the SDRAM controller. The upper address field selects
// the slave. Forward and return routing is combinational. Cycles to an
// unmapped select are answered locally with zero data. Slave interrupts are
// merged and registered.
// Build option: define WB_IC_TIMEOUT_EN to add a watchdog. The watchdog
// force-acks a cycle that stalls for TIMEOUT_CYCLES clocks.
module wishbone_interconnect_2s #(
  parameter int ADDR_SEL_MSB = 31,
  parameter int ADDR_SEL_LSB = 24,
  parameter logic [ADDR_SEL_MSB-ADDR_SEL_LSB:0] S0_SEL = 8'h00,
  parameter logic [ADDR_SEL_MSB-ADDR_SEL_LSB:0] S1_SEL = 8'h01,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_we_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  output logic        m_ack_o,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_adr_i,
  output logic        m_int_o,
  output logic        s0_we_o,
  output logic        s1_we_o,
  output logic        s0_cyc_o,
  output logic        s1_cyc_o,
  output logic        s0_stb_o,
  output logic        s1_stb_o,
  input  logic        s0_ack_i,
  input  logic        s1_ack_i,
  output logic [31:0] s0_dat_o,
  output logic [31:0] s1_dat_o,
  input  logic [31:0] s0_dat_i,
  input  logic [31:0] s1_dat_i,
  output logic [31:0] s0_adr_o,
  output logic [31:0] s1_adr_o,
  input  logic        s0_int_i,
  input  logic        s1_int_i
);

  localparam int SEL_W = ADDR_SEL_MSB - ADDR_SEL_LSB + 1;

  // Mask covering the select field, used to strip it from the slave address
  function automatic logic [31:0] sel_mask_f();
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if ((i >= ADDR_SEL_LSB) && (i <= ADDR_SEL_MSB)) m[i] = 1'b1;
      else                                            m[i] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [31:0] SEL_MASK = sel_mask_f();

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cyc_seen_q, cyc_seen_d;
  logic             um_ack_q, um_ack_d;
  logic             int_q, int_d;

  logic [SEL_W-1:0] sel_live_s, sel_eff_s;
  logic             hit0_s, hit1_s, unmapped_s;
  logic             ack_sel_s;
  logic             timeout_s;

  // Slave decode: live select on the first cycle, latched select afterwards
  always_comb begin
    sel_live_s = m_adr_i[ADDR_SEL_MSB:ADDR_SEL_LSB];
    if (cyc_seen_q) sel_eff_s = sel_q;
    else            sel_eff_s = sel_live_s;
    hit0_s     = (sel_eff_s == S0_SEL);
    hit1_s     = (sel_eff_s == S1_SEL) && !hit0_s;
    unmapped_s = !hit0_s && !hit1_s;
    ack_sel_s  = (hit0_s & s0_ack_i) | (hit1_s & s1_ack_i) | (unmapped_s & um_ack_q);
  end

  // Next-state for the select latch, the unmapped-ack pulse and the interrupt
  always_comb begin
    cyc_seen_d = m_cyc_i;
    if (!m_cyc_i)        sel_d = '0;
    else if (!cyc_seen_q) sel_d = sel_live_s;
    else                 sel_d = sel_q;
    // A pulse that has just been issued blocks the next one, so a held strobe is acked every other cycle
    um_ack_d = m_cyc_i & m_stb_i & unmapped_s & ~um_ack_q;
    int_d    = s0_int_i | s1_int_i;
  end

  // State registers for decode, the unmapped ack and the interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= '0;
      cyc_seen_q <= 1'b0;
      um_ack_q   <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      cyc_seen_q <= cyc_seen_d;
      um_ack_q   <= um_ack_d;
      int_q      <= int_d;
    end
  end

`ifdef WB_IC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog: count stalled strobe cycles and fire when the limit is reached
  always_comb begin
    timeout_s = m_cyc_i & m_stb_i & (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    if (!m_cyc_i || timeout_s || (m_stb_i && ack_sel_s)) to_cnt_d = '0;
    else if (m_stb_i)                                     to_cnt_d = to_cnt_q + TO_W'(1);
    else                                                  to_cnt_d = to_cnt_q;
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  // No watchdog in this build: a silent slave stalls the master
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Combinational routing of the forward and return paths, held idle during reset
  always_comb begin
    s0_dat_o = m_dat_i;
    s1_dat_o = m_dat_i;
    s0_adr_o = m_adr_i & ~SEL_MASK;
    s1_adr_o = m_adr_i & ~SEL_MASK;
    if (!rst) begin
      s0_cyc_o = 1'b0;
      s0_stb_o = 1'b0;
      s0_we_o  = 1'b0;
      s1_cyc_o = 1'b0;
      s1_stb_o = 1'b0;
      s1_we_o  = 1'b0;
      m_ack_o  = 1'b0;
      m_dat_o  = 32'h0;
    end else begin
      s0_cyc_o = hit0_s & m_cyc_i;
      s0_stb_o = hit0_s & m_stb_i & ~timeout_s;
      s0_we_o  = hit0_s & m_we_i;
      s1_cyc_o = hit1_s & m_cyc_i;
      s1_stb_o = hit1_s & m_stb_i & ~timeout_s;
      s1_we_o  = hit1_s & m_we_i;
      m_ack_o  = timeout_s | (m_cyc_i & m_stb_i & ack_sel_s);
      if (timeout_s)   m_dat_o = 32'hDEADDEAD;
      else if (hit0_s) m_dat_o = s0_dat_i;
      else if (hit1_s) m_dat_o = s1_dat_i;
      else             m_dat_o = 32'h0;
    end
  end

  assign m_int_o = int_q;

endmodule

// File: tb/tb_wishbone_interconnect_2s.sv
// Directed bench for wishbone_interconnect_2s. Stimulus pushes the expected
// routing snapshots and acks into queues. A monitor on the falling edge pops
// the queues and compares them with the DUT outputs.
module tb_wishbone_interconnect_2s;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_int_o;
  logic [31:0] m_dat_i, m_dat_o, m_adr_i;
  logic        s0_we_o, s1_we_o, s0_cyc_o, s1_cyc_o, s0_stb_o, s1_stb_o;
  logic        s0_ack_i, s1_ack_i, s0_int_i, s1_int_i;
  logic [31:0] s0_dat_o, s1_dat_o, s0_dat_i, s1_dat_i, s0_adr_o, s1_adr_o;

  wishbone_interconnect_2s dut (
    .clk(clk), .rst(rst),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_ack_o(m_ack_o),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_adr_i(m_adr_i), .m_int_o(m_int_o),
    .s0_we_o(s0_we_o), .s1_we_o(s1_we_o), .s0_cyc_o(s0_cyc_o), .s1_cyc_o(s1_cyc_o),
    .s0_stb_o(s0_stb_o), .s1_stb_o(s1_stb_o), .s0_ack_i(s0_ack_i), .s1_ack_i(s1_ack_i),
    .s0_dat_o(s0_dat_o), .s1_dat_o(s1_dat_o), .s0_dat_i(s0_dat_i), .s1_dat_i(s1_dat_i),
    .s0_adr_o(s0_adr_o), .s1_adr_o(s1_adr_o), .s0_int_i(s0_int_i), .s1_int_i(s1_int_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] tag;
    logic [7:0]  ctl;   // {s0 cyc,stb,we, s1 cyc,stb,we, m_ack, m_int}
    logic [1:0]  chk;   // bit0: m_dat_o, bit1: addresses and s1 write data
    logic [31:0] mdat;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d1;
  } route_t;

  typedef struct packed {
    logic [95:0] tag;
    logic [31:0] due;
    logic [31:0] dat;
  } ack_t;

  route_t rq[$];
  ack_t   aq[$];
  int     total = 0;
  int     bad   = 0;
  int     cyc_cnt = 0;
  route_t r;
  ack_t   a;
  logic [7:0] ctl_now;
  logic       ok;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare queued snapshots each cycle and pop an expected ack whenever m_ack_o is high
  always @(negedge clk) begin
    ctl_now = {s0_cyc_o, s0_stb_o, s0_we_o, s1_cyc_o, s1_stb_o, s1_we_o, m_ack_o, m_int_o};
    while (rq.size() > 0) begin
      r = rq.pop_front();
      ok = (ctl_now === r.ctl);
      if (r.chk[0]) ok = ok && (m_dat_o === r.mdat);
      if (r.chk[1]) ok = ok && (s0_adr_o === r.a0) && (s1_adr_o === r.a1) && (s1_dat_o === r.d1);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s cyc=%0d ctl got=%b want=%b m_dat got=%h want=%h adr0 got=%h want=%h adr1 got=%h want=%h s1_dat got=%h want=%h",
                 r.tag, cyc_cnt, ctl_now, r.ctl, m_dat_o, r.mdat, s0_adr_o, r.a0, s1_adr_o, r.a1, s1_dat_o, r.d1);
      end
    end
    if (m_ack_o === 1'b1) begin
      total++;
      if (aq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack cyc=%0d got ack=1 dat=%h want no ack", cyc_cnt, m_dat_o);
      end else begin
        a = aq.pop_front();
        if ((m_dat_o !== a.dat) || (cyc_cnt != int'(a.due))) begin
          bad++;
          $display("FAIL %s ack got cyc=%0d dat=%h want cyc=%0d dat=%h", a.tag, cyc_cnt, m_dat_o, a.due, a.dat);
        end
      end
    end
  end

  task automatic exp_route(input logic [95:0] tag, input logic [7:0] ctl, input logic [1:0] chk,
                           input logic [31:0] mdat, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d1);
    route_t e;
    e.tag = tag; e.ctl = ctl; e.chk = chk; e.mdat = mdat; e.a0 = a0; e.a1 = a1; e.d1 = d1;
    rq.push_back(e);
  endtask

  task automatic exp_ack(input logic [95:0] tag, input int due, input logic [31:0] dat);
    ack_t e;
    e.tag = tag; e.due = 32'(due); e.dat = dat;
    aq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    s0_ack_i = 1'b0; s1_ack_i = 1'b0;
    exp_route("idle", 8'b000_000_0_0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    m_dat_i = 32'h0; m_adr_i = 32'h0;
    s0_ack_i = 1'b1; s1_ack_i = 1'b0;
    s0_dat_i = 32'h0BAD_F00D; s1_dat_i = 32'h0;
    s0_int_i = 1'b0; s1_int_i = 1'b1;
    tick();

    // Reset held with an active master and an acking slave
    for (int k = 0; k < 3; k++) begin
      exp_route("reset_hold", 8'b000_000_0_0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
    end
    rst = 1'b1; s1_int_i = 1'b0;
    exp_route("reset_rel", 8'b110_000_1_0, 2'b01, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0);
    exp_ack("reset_rel", cyc_cnt, 32'h0BAD_F00D);
    tick();
    go_idle();
    go_idle();

    // Slave 0 read, wait state then ack
    m_adr_i = 32'h0000_0003; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
    s0_dat_i = 32'h1234_5678;
    exp_route("s0_rd_wait", 8'b110_000_0_0, 2'b11, 32'h1234_5678, 32'h3, 32'h3, 32'h0);
    tick();
    s0_ack_i = 1'b1;
    exp_route("s0_rd_ack", 8'b110_000_1_0, 2'b11, 32'h1234_5678, 32'h3, 32'h3, 32'h0);
    exp_ack("s0_rd", cyc_cnt, 32'h1234_5678);
    tick();
    go_idle();

    // Slave 1 write; slave 0 acks at the same time and must be ignored
    m_adr_i = 32'h0100_0010; m_we_i = 1'b1; m_dat_i = 32'h0000_1EAF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    s1_ack_i = 1'b1; s0_ack_i = 1'b1;
    s1_dat_i = 32'hCAFE_F00D; s0_dat_i = 32'h1111_1111;
    exp_route("s1_wr", 8'b000_111_1_0, 2'b11, 32'hCAFE_F00D, 32'h10, 32'h10, 32'h0000_1EAF);
    exp_ack("s1_wr", cyc_cnt, 32'hCAFE_F00D);
    tick();
    go_idle();

    // Unmapped read with the strobe held: acks on the 2nd and 4th cycles, data 0
    m_adr_i = 32'h0500_0000; m_dat_i = 32'h0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    s0_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_route("unmap_rd", (k % 2 == 1) ? 8'b000_000_1_0 : 8'b000_000_0_0, 2'b11,
                32'h0, 32'h0, 32'h0, 32'h0);
      if (k % 2 == 1) exp_ack("unmap_rd", cyc_cnt, 32'h0);
      tick();
    end
    go_idle();

    // Unmapped write: nothing strobed, single ack one clock later
    m_adr_i = 32'hFF00_0044; m_we_i = 1'b1; m_dat_i = 32'h0000_0077;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    exp_route("unmap_wr0", 8'b000_000_0_0, 2'b11, 32'h0, 32'h44, 32'h44, 32'h77);
    tick();
    exp_route("unmap_wr1", 8'b000_000_1_0, 2'b11, 32'h0, 32'h44, 32'h44, 32'h77);
    exp_ack("unmap_wr", cyc_cnt, 32'h0);
    tick();
    go_idle();

    // Address change mid-cycle keeps slave 1 until cyc falls
    m_adr_i = 32'h0100_0000; m_dat_i = 32'h0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    s1_dat_i = 32'hA5A5_0001; s0_dat_i = 32'h5A5A_0000;
    exp_route("mid_start", 8'b000_110_0_0, 2'b11, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
    tick();
    m_adr_i = 32'h0000_0000;
    exp_route("mid_switch", 8'b000_110_0_0, 2'b11, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
    tick();
    s1_ack_i = 1'b1; s0_ack_i = 1'b1;
    exp_route("mid_ack", 8'b000_110_1_0, 2'b01, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
    exp_ack("mid_ack", cyc_cnt, 32'hA5A5_0001);
    tick();
    go_idle();
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    exp_route("mid_new_s0", 8'b110_000_0_0, 2'b01, 32'h5A5A_0000, 32'h0, 32'h0, 32'h0);
    tick();
    go_idle();

    // Interrupt: 3-cycle pulse on slave 1 appears one clock later
    for (int k = 0; k < 6; k++) begin
      s1_int_i = (k < 3) ? 1'b1 : 1'b0;
      exp_route("irq", ((k >= 1) && (k <= 3)) ? 8'b000_000_0_1 : 8'b000_000_0_0, 2'b00,
                32'h0, 32'h0, 32'h0, 32'h0);
      tick();
    end

    // Silent slave 1: watchdog ack after 256 stalled cycles when built in
    m_adr_i = 32'h0100_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1; s1_dat_i = 32'h0000_5151;
    for (int k = 0; k < 300; k++) begin
      if ((k == 0) || (k == 255) || (k == 257) || (k == 299))
        exp_route("stall", 8'b000_110_0_0, 2'b01, 32'h0000_5151, 32'h0, 32'h0, 32'h0);
`ifdef WB_IC_TIMEOUT_EN
      if (k == 256) begin
        exp_route("timeout", 8'b000_100_1_0, 2'b01, 32'hDEAD_DEAD, 32'h0, 32'h0, 32'h0);
        exp_ack("timeout", cyc_cnt, 32'hDEAD_DEAD);
      end
`else
      if (k == 256)
        exp_route("no_timeout", 8'b000_110_0_0, 2'b01, 32'h0000_5151, 32'h0, 32'h0, 32'h0);
`endif
      tick();
    end
    go_idle();
    go_idle();

    total++;
    if (aq.size() != 0) begin
      bad++;
      $display("FAIL ack_missing got pending=%0d want 0", aq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
